// File: rtl/uart_hex_frame_parser.sv
// ASCII-hex line to binary frame converter: buffers one line of hex text from the
// UART receiver and replays it as a valid/ready byte stream with a last flag.
module uart_hex_frame_parser #(
  parameter int MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_byte_en,
  input  logic [7:0] rx_byte,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_last,
  input  logic       tx_ready,
  output logic       err_pulse,
  output logic [1:0] err_code
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] ERR_BUSY     = 2'd0;
  localparam logic [1:0] ERR_ODD      = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_DISCARD,
    S_SEND
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [3:0]       nib_hi_q, nib_hi_d;
  logic             nib_odd_q, nib_odd_d;
  logic [1:0]       err_stored_q, err_stored_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_last_q, tx_last_d;
  logic             err_pulse_q, err_pulse_d;
  logic [1:0]       err_code_q, err_code_d;

  logic [7:0]       mem_q [2**AW];
  logic             wr_en;
  logic [7:0]       wr_data;

  // Character classification; letters map via their low nibble (a/A = x1 -> 10).
  logic       is_digit, is_alpha, is_hex, is_ws, is_term;
  logic [3:0] nib;
  logic [AW-1:0] rd_inc;
  logic       len_full;

  assign is_digit = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
  assign is_alpha = ((rx_byte >= 8'h41) && (rx_byte <= 8'h46)) ||
                    ((rx_byte >= 8'h61) && (rx_byte <= 8'h66));
  assign is_hex   = is_digit || is_alpha;
  assign is_ws    = (rx_byte == 8'h20) || (rx_byte == 8'h09);
  assign is_term  = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
  assign nib      = is_digit ? rx_byte[3:0] : (rx_byte[3:0] + 4'd9);
  assign rd_inc   = rd_q + AW'(1);
  assign len_full = (len_q == LEN_W'(MAX_LEN));

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d      = state_q;
    len_d        = len_q;
    rd_d         = rd_q;
    nib_hi_d     = nib_hi_q;
    nib_odd_d    = nib_odd_q;
    err_stored_d = err_stored_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    tx_last_d    = tx_last_q;
    err_pulse_d  = 1'b0;
    err_code_d   = err_code_q;
    wr_en        = 1'b0;
    wr_data      = {nib_hi_q, nib};

    unique case (state_q)
      S_COLLECT: begin
        if (rx_byte_en) begin
          if (is_hex) begin
            if (!nib_odd_q) begin
              nib_hi_d  = nib;
              nib_odd_d = 1'b1;
            end else if (len_full) begin
              state_d      = S_DISCARD;
              err_stored_d = ERR_OVERFLOW;
            end else begin
              wr_en     = 1'b1;
              len_d     = len_q + LEN_W'(1);
              nib_odd_d = 1'b0;
            end
          end else if (is_term) begin
            if (nib_odd_q) begin
              err_pulse_d = 1'b1;
              err_code_d  = ERR_ODD;
              len_d       = '0;
              nib_odd_d   = 1'b0;
            end else if (len_q != '0) begin
              // Last byte was written at least one strobe earlier, so mem_q[0] is settled.
              state_d    = S_SEND;
              rd_d       = '0;
              tx_valid_d = 1'b1;
              tx_data_d  = mem_q[0];
              tx_last_d  = (len_q == LEN_W'(1));
            end
          end else if (!is_ws) begin
            state_d      = S_DISCARD;
            err_stored_d = ERR_ILLEGAL;
          end
        end
      end

      S_DISCARD: begin
        if (rx_byte_en && is_term) begin
          err_pulse_d = 1'b1;
          err_code_d  = err_stored_q;
          len_d       = '0;
          nib_odd_d   = 1'b0;
          state_d     = S_COLLECT;
        end
      end

      S_SEND: begin
        if (rx_byte_en) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_BUSY;
        end
        if (tx_valid_q && tx_ready) begin
          if (tx_last_q) begin
            state_d    = S_COLLECT;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            len_d      = '0;
            rd_d       = '0;
            nib_odd_d  = 1'b0;
          end else begin
            rd_d      = rd_inc;
            tx_data_d = mem_q[rd_inc];
            tx_last_d = (LEN_W'(rd_inc) == (len_q - LEN_W'(1)));
          end
        end
      end

      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_COLLECT;
      len_q        <= '0;
      rd_q         <= '0;
      nib_hi_q     <= '0;
      nib_odd_q    <= 1'b0;
      err_stored_q <= ERR_BUSY;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_last_q    <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rd_q         <= rd_d;
      nib_hi_q     <= nib_hi_d;
      nib_odd_q    <= nib_odd_d;
      err_stored_q <= err_stored_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      tx_last_q    <= tx_last_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
    end
  end

  // NOTE: the frame buffer has no reset; len_q gates every read, so stale bytes never escape.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[len_q[AW-1:0]] <= wr_data;
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign tx_last   = tx_last_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_hex_frame_parser.sv
// Directed bench for uart_hex_frame_parser with a 4-byte buffer so overflow is reachable
// alongside the normal, back-pressure, format-error and reset scenarios.
module tb_uart_hex_frame_parser;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx_byte_en = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready = 1'b1;
  logic       err_pulse;
  logic [1:0] err_code;

  uart_hex_frame_parser #(.MAX_LEN(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_byte_en (rx_byte_en),
    .rx_byte    (rx_byte),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .err_pulse  (err_pulse),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_strobe_cyc = 0;
  int valid_cycles = 0;
  logic [8:0] out_q [$];
  int         out_cyc_q [$];
  logic [1:0] err_q [$];
  logic       stall_pending = 1'b0;
  logic [9:0] stall_val = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    if (!rstn) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        check("hold_during_stall", {tx_valid, tx_last, tx_data}, stall_val);
        stall_pending = 1'b0;
      end
      if (tx_valid) begin
        valid_cycles++;
        check("no_x_when_valid", 32'($isunknown({tx_data, tx_last})), 32'd0);
        if (tx_ready) begin
          out_q.push_back({tx_last, tx_data});
          out_cyc_q.push_back(cyc);
        end else begin
          stall_pending = 1'b1;
          stall_val     = {tx_valid, tx_last, tx_data};
        end
      end
      if (err_pulse) err_q.push_back(err_code);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_char(input byte c);
    @(posedge clk);
    #1;
    rx_byte_en      = 1'b1;
    rx_byte         = c;
    last_strobe_cyc = cyc;
    @(posedge clk);
    #1;
    rx_byte_en = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic clear_obs();
    out_q.delete();
    out_cyc_q.delete();
    err_q.delete();
    valid_cycles = 0;
  endtask

  initial begin
    #12;
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_tx_last", 32'(tx_last), 32'd0);
    check("reset_err_pulse", 32'(err_pulse), 32'd0);
    check("reset_err_code", 32'(err_code), 32'd0);
    rstn = 1'b1;
    idle(2);

    // Well-formed line, consumer always ready.
    clear_obs();
    send_str("A5 3c\n");
    idle(6);
    check("t1_count", out_q.size(), 2);
    check("t1_byte0", 32'(out_q[0]), 32'h0A5);
    check("t1_byte1", 32'(out_q[1]), 32'h13C);
    check("t1_lat0", out_cyc_q[0] - last_strobe_cyc, 1);
    check("t1_lat1", out_cyc_q[1] - last_strobe_cyc, 2);
    check("t1_errs", err_q.size(), 0);

    // Back-pressure: ready pattern 1,0,0 repeating; LF lands during SEND.
    clear_obs();
    fork
      send_str("01020304\r\n");
      begin
        for (int k = 0; k < 40; k++) begin
          tx_ready = (k % 3) == 0;
          @(posedge clk);
          #1;
        end
        tx_ready = 1'b1;
      end
    join
    idle(5);
    check("t2_count", out_q.size(), 4);
    check("t2_byte0", 32'(out_q[0]), 32'h001);
    check("t2_byte1", 32'(out_q[1]), 32'h002);
    check("t2_byte2", 32'(out_q[2]), 32'h003);
    check("t2_byte3", 32'(out_q[3]), 32'h104);
    check("t2_err_count", err_q.size(), 1);
    check("t2_err_code", 32'(err_q[0]), 32'd0);

    // Odd nibble count.
    clear_obs();
    send_str("ABC\r");
    idle(4);
    check("t3_err_count", err_q.size(), 1);
    check("t3_err_code", 32'(err_q[0]), 32'd1);
    check("t3_no_valid", valid_cycles, 0);

    // Illegal character.
    clear_obs();
    send_str("1G 22\n");
    idle(4);
    check("t4_err_count", err_q.size(), 1);
    check("t4_err_code", 32'(err_q[0]), 32'd2);
    check("t4_no_valid", valid_cycles, 0);

    // Blank lines.
    clear_obs();
    send_str("\r\n\r\n");
    idle(4);
    check("t5_no_err", err_q.size(), 0);
    check("t5_no_valid", valid_cycles, 0);

    // Overflow of the 4-byte buffer, then recovery.
    clear_obs();
    send_str("0102030405\n");
    idle(4);
    check("t6_err_count", err_q.size(), 1);
    check("t6_err_code", 32'(err_q[0]), 32'd3);
    check("t6_no_valid", valid_cycles, 0);
    clear_obs();
    send_str("FF\n");
    idle(5);
    check("t7_count", out_q.size(), 1);
    check("t7_byte0", 32'(out_q[0]), 32'h1FF);
    check("t7_errs", err_q.size(), 0);

    // Reset while the second byte of a 3-byte frame is pending.
    clear_obs();
    tx_ready = 1'b0;
    send_str("112233\n");
    begin
      int budget = 10;
      while (!tx_valid && budget > 0) begin
        idle(1);
        budget--;
      end
      check("t8_valid_timeout", 32'(tx_valid), 32'd1);
    end
    tx_ready = 1'b1;
    idle(1);
    tx_ready = 1'b0;
    check("t8_pending_byte1", {23'd0, tx_last, tx_data}, 32'h022);
    rstn = 1'b0;
    #1;
    check("t8_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("t8_rst_tx_data", 32'(tx_data), 32'd0);
    check("t8_rst_tx_last", 32'(tx_last), 32'd0);
    check("t8_rst_err_pulse", 32'(err_pulse), 32'd0);
    idle(2);
    rstn = 1'b1;
    tx_ready = 1'b1;
    idle(1);
    clear_obs();
    send_str("7E\n");
    idle(5);
    check("t8_count", out_q.size(), 1);
    check("t8_byte0", 32'(out_q[0]), 32'h17E);
    check("t8_idle_after", 32'(tx_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_hex_frame_parser.md
# uart_hex_frame_parser

Converts the received UART byte stream (one-cycle `rx_byte_en` strobes with `rx_byte`) from ASCII hex text lines into binary frames, buffers one complete frame, and emits it as a valid/ready byte stream with a last flag. It sits directly downstream of the UART receiver and upstream of the frame transmitter (NFC command encoder).

## Interface
- `MAX_LEN`, default 64: frame buffer depth in bytes, legal range 1..256.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `rx_byte_en`  in  1  one-cycle strobe: `rx_byte` is valid this cycle.
- `rx_byte`  in  8  received ASCII character.
- `tx_valid`  out  1  frame byte available on `tx_data`.
- `tx_data`  out  8  frame byte, first-received byte first.
- `tx_last`  out  1  qualifies the final byte of the frame.
- `tx_ready`  in  1  consumer accepts `tx_data` when `tx_valid & tx_ready`.
- `err_pulse`  out  1  one-cycle error strobe.
- `err_code`  out  2  error cause, valid when `err_pulse` is high: 0 = busy drop, 1 = odd nibble count, 2 = illegal character, 3 = overflow.

## Operation
- Character classes:
  - hex digit: `0`-`9`, `a`-`f`, `A`-`F`;
  - ignored: space 0x20, tab 0x09;
  - terminator: CR 0x0D, LF 0x0A;
  - anything else is illegal.
- Nibble pairing: nibbles pair in arrival order, regardless of any spaces between them. The first nibble of a pair is the high nibble. A completed pair is written to `buf[len]` and `len` increments. `len` is `$clog2(MAX_LEN+1)` bits wide.
- COLLECT (reset state):
  - hex digit: accumulate the nibble.
  - Completing a byte while `len == MAX_LEN`: go to DISCARD, error code 3.
  - Illegal character: go to DISCARD, error code 2.
  - Terminator with 0 nibbles: ignored silently, so CRLF and blank lines produce nothing.
  - Terminator with an odd nibble count: error 1, clear the buffer, stay in COLLECT.
  - Terminator with `len >= 1` and an even nibble count: go to SEND, read pointer = 0.
- DISCARD:
  - All non-terminator characters are ignored.
  - On a terminator: pulse the stored error code (2 or 3), clear the buffer, go to COLLECT.
  - A later error does not overwrite the first stored cause.
- SEND:
  - `tx_valid = 1`, `tx_data = buf[rd]`, `tx_last = (rd == len-1)`.
  - Each handshake increments `rd`.
  - A handshake with `tx_last` clears `len` and the nibble state and returns to COLLECT.
  - Any `rx_byte_en` while in SEND, including the cycle of the final handshake, drops the character and pulses error 0. Only one line is buffered.
- `tx_data` and `tx_last` are don't-care when `tx_valid` is 0, but the bench checks them for X only while `tx_valid` is high.

## Timing
- Reset values: `tx_valid = 0`, `tx_data = 0`, `tx_last = 0`, `err_pulse = 0`, `err_code = 0`. The state machine resets to COLLECT with `len`, `rd` and nibble state cleared. Reset mid-frame or mid-send discards all content.
- Terminator strobe at cycle t, good line: `tx_valid` is high from cycle t+1 with `buf[0]`.
- Streaming: one byte per cycle while `tx_ready` stays high, with no bubbles. `tx_valid`, `tx_data` and `tx_last` hold stable while `tx_ready` is low.
- End of frame: `tx_valid` falls in the cycle after the `tx_last` handshake. The parser accepts new characters from that cycle onward.
- Error latency:
  - `err_pulse` is registered and asserts at t+1 for a strobe at t.
  - Exactly one pulse per erroneous line.
  - One pulse per dropped character in SEND.
- `rx_byte_en` is never asserted on consecutive cycles by the upstream receiver. The block nonetheless handles back-to-back strobes correctly.
- Throughput: COLLECT processes one character per strobe with no stall. There is no backpressure toward the UART.

## Test plan
- Well-formed line: send "A5 3c\n" with `tx_ready` = 1.
  - Expect 0xA5 with last = 0, then 0x3C with last = 1, on consecutive cycles starting one cycle after the LF strobe.
  - No `err_pulse`.
- Back-pressure: send "01020304\r\n" and toggle `tx_ready` 1,0,0,1,...
  - Expect output 01,02,03,04 with `tx_data` held during stalls and `tx_last` only on 04.
  - The trailing LF arrives during SEND, so expect exactly one `err_pulse` with code 0.
- Format errors:
  - "ABC\r" gives `err_code` 1 and no `tx_valid`.
  - "1G 22\n" gives `err_code` 2 and no `tx_valid`.
  - "\r\n\r\n" gives no output and no error.
- Overflow, with `MAX_LEN` = 4:
  - "0102030405\n" gives one `err_pulse` with code 3 and no output.
  - A following "FF\n" is then emitted as a single byte 0xFF with last = 1.
- Reset mid-send: assert `rstn` low while the 2nd byte of a 3-byte frame is pending.
  - All outputs are 0 immediately.
  - After release, "7E\n" yields a single 0x7E.
